// File: rtl/matmul_pkg.sv
// Shared constants for the matrix-multiplier datapath and its result drain stage.
package matmul_pkg;

    localparam int unsigned ELEMS = 16;
    localparam int unsigned DW    = 32;
    localparam int unsigned IDX_W = $clog2(ELEMS);
    localparam int unsigned IN_W  = 8;

    // Occupancy encodings of the two-slot drain buffer.
    localparam logic [1:0] CNT_EMPTY = 2'd0;
    localparam logic [1:0] CNT_ONE   = 2'd1;
    localparam logic [1:0] CNT_FULL  = 2'd2;

endpackage

// File: rtl/matmul_drain.sv
// Result drain: captures 512-bit multiplier vectors into a ping-pong buffer and
// streams them out as 16 sequential 32-bit words over valid/ready.
module matmul_drain
    import matmul_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  vld_i,
    input  logic [ELEMS*DW-1:0]   matmul_i,
    output logic [DW-1:0]         dout_o,
    output logic                  dout_vld_o,
    input  logic                  dout_rdy_i,
    output logic [IDX_W-1:0]      dout_idx_o,
    output logic                  dout_last_o,
    output logic                  full_o,
    output logic                  ovf_o,
    input  logic                  ovf_clr_i
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ELEMS - 1);

    logic [ELEMS*DW-1:0] slot [2];
    logic                wr_ptr;
    logic                rd_ptr;
    logic [1:0]          count;
    logic [1:0]          count_nxt;
    logic [IDX_W-1:0]    idx;
    logic                ovf;

    logic beat;
    logic frame_end;
    logic cap;
    logic drop;

    always_comb begin
        beat      = (count != CNT_EMPTY) && dout_rdy_i;
        frame_end = beat && (idx == LAST_IDX);
        // A full buffer can still accept when its head frame completes this cycle.
        cap       = vld_i && ((count != CNT_FULL) || frame_end);
        drop      = vld_i && (count == CNT_FULL) && !frame_end;
    end

    always_comb begin
        count_nxt = count;
        case (count)
            CNT_EMPTY: if (cap) count_nxt = CNT_ONE;
            CNT_ONE: begin
                if (cap && !frame_end)      count_nxt = CNT_FULL;
                else if (frame_end && !cap) count_nxt = CNT_EMPTY;
            end
            CNT_FULL:  if (frame_end && !cap) count_nxt = CNT_ONE;
            default:   count_nxt = CNT_EMPTY;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            slot[0] <= '0;
            slot[1] <= '0;
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            count   <= CNT_EMPTY;
            idx     <= '0;
            ovf     <= 1'b0;
        end else begin
            // When FULL with a coincident frame end, wr_ptr equals rd_ptr, so the
            // new vector lands in the slot being released.
            if (cap) begin
                slot[wr_ptr] <= matmul_i;
                wr_ptr       <= ~wr_ptr;
            end
            if (frame_end) begin
                idx    <= '0;
                rd_ptr <= ~rd_ptr;
            end else if (beat) begin
                idx <= idx + 1'b1;
            end
            count <= count_nxt;
            if (drop)           ovf <= 1'b1;
            else if (ovf_clr_i) ovf <= 1'b0;
        end
    end

    assign dout_o      = slot[rd_ptr][idx*DW +: DW];
    assign dout_vld_o  = (count != CNT_EMPTY);
    assign dout_idx_o  = idx;
    assign dout_last_o = dout_vld_o && (idx == LAST_IDX);
    assign full_o      = (count == CNT_FULL);
    assign ovf_o       = ovf;

endmodule

// File: tb/tb_matmul_drain.sv
// Self-checking bench for matmul_drain: scoreboard of expected beats plus a
// table of occupancy/overflow steps and hand-written corner sequences.
module tb_matmul_drain;
    import matmul_pkg::*;

    localparam int unsigned     VW   = ELEMS * DW;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(ELEMS - 1);

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              vld_i;
    logic [VW-1:0]     matmul_i;
    logic [DW-1:0]     dout_o;
    logic              dout_vld_o;
    logic              dout_rdy_i;
    logic [IDX_W-1:0]  dout_idx_o;
    logic              dout_last_o;
    logic              full_o;
    logic              ovf_o;
    logic              ovf_clr_i;

    matmul_drain dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .vld_i       (vld_i),
        .matmul_i    (matmul_i),
        .dout_o      (dout_o),
        .dout_vld_o  (dout_vld_o),
        .dout_rdy_i  (dout_rdy_i),
        .dout_idx_o  (dout_idx_o),
        .dout_last_o (dout_last_o),
        .full_o      (full_o),
        .ovf_o       (ovf_o),
        .ovf_clr_i   (ovf_clr_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [DW-1:0]    data;
        logic [IDX_W-1:0] idx;
    } beat_t;

    typedef struct {
        logic          vld;
        logic [DW-1:0] base;
        logic          acc;
        logic          clr;
        logic          exp_full;
        logic          exp_ovf;
    } row_t;

    beat_t         sb[$];
    row_t          tbl[7];
    int unsigned   checks   = 0;
    int unsigned   failures = 0;
    logic          pend;
    logic [DW-1:0] pend_base;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [VW-1:0] build(input logic [DW-1:0] base);
        logic [VW-1:0] v;
        for (int unsigned k = 0; k < ELEMS; k++) v[k*DW +: DW] = base + DW'(k);
        return v;
    endfunction

    // Checks the presented word against the scoreboard head, then advances one cycle.
    task automatic tick();
        if (!rst_i) begin
            chk("dout_vld_o", {31'b0, dout_vld_o}, {31'b0, sb.size() != 0});
            if (dout_vld_o && sb.size() != 0) begin
                chk("dout_o", dout_o, sb[0].data);
                chk("dout_idx_o", {28'b0, dout_idx_o}, {28'b0, sb[0].idx});
                chk("dout_last_o", {31'b0, dout_last_o}, {31'b0, sb[0].idx == LAST});
                if (dout_rdy_i) void'(sb.pop_front());
            end else begin
                chk("dout_last_o_idle", {31'b0, dout_last_o}, 32'd0);
            end
        end
        @(posedge clk_i);
        #1;
        if (rst_i) begin
            sb.delete();
        end else if (pend) begin
            for (int unsigned k = 0; k < ELEMS; k++) begin
                beat_t b;
                b.data = pend_base + DW'(k);
                b.idx  = IDX_W'(k);
                sb.push_back(b);
            end
        end
        pend = 1'b0;
    endtask

    task automatic capture(input logic [DW-1:0] base, input logic acc);
        vld_i     = 1'b1;
        matmul_i  = build(base);
        pend      = acc;
        pend_base = base;
        tick();
        vld_i     = 1'b0;
    endtask

    task automatic run(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{vld: 1'b1, base: 32'hA000_0000, acc: 1'b1, clr: 1'b0, exp_full: 1'b0, exp_ovf: 1'b0};
        tbl[1] = '{vld: 1'b1, base: 32'hB000_0000, acc: 1'b1, clr: 1'b0, exp_full: 1'b1, exp_ovf: 1'b0};
        tbl[2] = '{vld: 1'b1, base: 32'hC000_0000, acc: 1'b0, clr: 1'b0, exp_full: 1'b1, exp_ovf: 1'b1};
        tbl[3] = '{vld: 1'b0, base: 32'h0,         acc: 1'b0, clr: 1'b0, exp_full: 1'b1, exp_ovf: 1'b1};
        tbl[4] = '{vld: 1'b0, base: 32'h0,         acc: 1'b0, clr: 1'b1, exp_full: 1'b1, exp_ovf: 1'b0};
        tbl[5] = '{vld: 1'b1, base: 32'hD000_0000, acc: 1'b0, clr: 1'b1, exp_full: 1'b1, exp_ovf: 1'b1};
        tbl[6] = '{vld: 1'b0, base: 32'h0,         acc: 1'b0, clr: 1'b1, exp_full: 1'b1, exp_ovf: 1'b0};

        rst_i      = 1'b1;
        vld_i      = 1'b0;
        matmul_i   = '0;
        dout_rdy_i = 1'b0;
        ovf_clr_i  = 1'b0;
        pend       = 1'b0;
        pend_base  = '0;
        run(2);
        chk("rst_dout_o", dout_o, 32'd0);
        chk("rst_vld", {31'b0, dout_vld_o}, 32'd0);
        chk("rst_last", {31'b0, dout_last_o}, 32'd0);
        chk("rst_full", {31'b0, full_o}, 32'd0);
        chk("rst_ovf", {31'b0, ovf_o}, 32'd0);
        chk("rst_idx", {28'b0, dout_idx_o}, 32'd0);
        rst_i = 1'b0;

        // Single vector, ready held high.
        dout_rdy_i = 1'b1;
        capture(32'h1000_0000, 1'b1);
        run(18);

        // Backpressure at index 3.
        capture(32'h1000_0000, 1'b1);
        run(3);
        dout_rdy_i = 1'b0;
        chk("bp_word", dout_o, 32'h1000_0003);
        run(5);
        chk("bp_hold_word", dout_o, 32'h1000_0003);
        chk("bp_hold_idx", {28'b0, dout_idx_o}, 32'd3);
        dout_rdy_i = 1'b1;
        run(15);

        // Fill, overflow and set/clear collision with ready low.
        dout_rdy_i = 1'b0;
        foreach (tbl[i]) begin
            vld_i     = tbl[i].vld;
            matmul_i  = build(tbl[i].base);
            pend      = tbl[i].vld && tbl[i].acc;
            pend_base = tbl[i].base;
            ovf_clr_i = tbl[i].clr;
            tick();
            chk($sformatf("tbl%0d_full", i), {31'b0, full_o}, {31'b0, tbl[i].exp_full});
            chk($sformatf("tbl%0d_ovf", i), {31'b0, ovf_o}, {31'b0, tbl[i].exp_ovf});
        end
        vld_i      = 1'b0;
        ovf_clr_i  = 1'b0;
        dout_rdy_i = 1'b1;
        run(34);
        chk("drain_full", {31'b0, full_o}, 32'd0);

        // Frame end coincident with capture while full.
        dout_rdy_i = 1'b0;
        capture(32'hA100_0000, 1'b1);
        capture(32'hB100_0000, 1'b1);
        chk("sim_full", {31'b0, full_o}, 32'd1);
        dout_rdy_i = 1'b1;
        run(15);
        chk("sim_last_idx", {28'b0, dout_idx_o}, 32'd15);
        capture(32'hC100_0000, 1'b1);
        chk("sim_ovf", {31'b0, ovf_o}, 32'd0);
        chk("sim_full_after", {31'b0, full_o}, 32'd1);
        run(34);

        // Reset mid-frame with a second vector queued; reset also overrides vld_i.
        capture(32'hA200_0000, 1'b1);
        capture(32'hB200_0000, 1'b1);
        run(6);
        chk("mid_idx", {28'b0, dout_idx_o}, 32'd7);
        rst_i     = 1'b1;
        vld_i     = 1'b1;
        matmul_i  = build(32'hE200_0000);
        ovf_clr_i = 1'b1;
        tick();
        vld_i     = 1'b0;
        ovf_clr_i = 1'b0;
        rst_i     = 1'b0;
        chk("mid_rst_dout", dout_o, 32'd0);
        chk("mid_rst_vld", {31'b0, dout_vld_o}, 32'd0);
        chk("mid_rst_idx", {28'b0, dout_idx_o}, 32'd0);
        chk("mid_rst_last", {31'b0, dout_last_o}, 32'd0);
        chk("mid_rst_full", {31'b0, full_o}, 32'd0);
        chk("mid_rst_ovf", {31'b0, ovf_o}, 32'd0);
        run(2);
        capture(32'hD200_0000, 1'b1);
        run(18);

        chk("sb_empty", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
